// File: rtl/rw_arbiter_if.sv
// Bundle of the three cache-side request ports (ic/dc/uc) and the single
// request/completion path toward the AXI read/write master.
//
// Handshake: a port raises *_valid_i and holds its request fields until
// its *_ready_o pulses for one cycle. On the master side rw_valid_o stays
// high with stable fields until rw_ready_i pulses for one cycle.
interface rw_arbiter_if #(
  parameter int RW_ADDR_WIDTH = 64,
  parameter int RW_DATA_WIDTH = 64,
  parameter int ID_WIDTH      = 4
);
  // icache port
  logic                     ic_valid_i;
  logic                     ic_ready_o;
  logic                     ic_req_i;
  logic [RW_ADDR_WIDTH-1:0] ic_addr_i;
  logic [1:0]               ic_size_i;
  logic [RW_DATA_WIDTH-1:0] ic_wdata_i;
  logic [7:0]               ic_wmask_i;
  logic [RW_DATA_WIDTH-1:0] ic_rdata_o;
  logic [1:0]               ic_resp_o;
  // dcache port
  logic                     dc_valid_i;
  logic                     dc_ready_o;
  logic                     dc_req_i;
  logic [RW_ADDR_WIDTH-1:0] dc_addr_i;
  logic [1:0]               dc_size_i;
  logic [RW_DATA_WIDTH-1:0] dc_wdata_i;
  logic [7:0]               dc_wmask_i;
  logic [RW_DATA_WIDTH-1:0] dc_rdata_o;
  logic [1:0]               dc_resp_o;
  // uncached port
  logic                     uc_valid_i;
  logic                     uc_ready_o;
  logic                     uc_req_i;
  logic [RW_ADDR_WIDTH-1:0] uc_addr_i;
  logic [1:0]               uc_size_i;
  logic [RW_DATA_WIDTH-1:0] uc_wdata_i;
  logic [7:0]               uc_wmask_i;
  logic [RW_DATA_WIDTH-1:0] uc_rdata_o;
  logic [1:0]               uc_resp_o;
  // AXI master side
  logic                     rw_valid_o;
  logic                     rw_req_o;
  logic [RW_ADDR_WIDTH-1:0] rw_addr_o;
  logic [1:0]               rw_size_o;
  logic [RW_DATA_WIDTH-1:0] data_write_o;
  logic [7:0]               w_mask_o;
  logic [ID_WIDTH-1:0]      rw_id_o;
  logic                     rw_ready_i;
  logic [RW_DATA_WIDTH-1:0] data_read_i;
  logic [1:0]               rw_resp_i;

  // Arbiter side
  modport slave (
    input  ic_valid_i, ic_req_i, ic_addr_i, ic_size_i, ic_wdata_i, ic_wmask_i,
    output ic_ready_o, ic_rdata_o, ic_resp_o,
    input  dc_valid_i, dc_req_i, dc_addr_i, dc_size_i, dc_wdata_i, dc_wmask_i,
    output dc_ready_o, dc_rdata_o, dc_resp_o,
    input  uc_valid_i, uc_req_i, uc_addr_i, uc_size_i, uc_wdata_i, uc_wmask_i,
    output uc_ready_o, uc_rdata_o, uc_resp_o,
    output rw_valid_o, rw_req_o, rw_addr_o, rw_size_o, data_write_o, w_mask_o, rw_id_o,
    input  rw_ready_i, data_read_i, rw_resp_i
  );

  // Requesters plus AXI master side
  modport master (
    output ic_valid_i, ic_req_i, ic_addr_i, ic_size_i, ic_wdata_i, ic_wmask_i,
    input  ic_ready_o, ic_rdata_o, ic_resp_o,
    output dc_valid_i, dc_req_i, dc_addr_i, dc_size_i, dc_wdata_i, dc_wmask_i,
    input  dc_ready_o, dc_rdata_o, dc_resp_o,
    output uc_valid_i, uc_req_i, uc_addr_i, uc_size_i, uc_wdata_i, uc_wmask_i,
    input  uc_ready_o, uc_rdata_o, uc_resp_o,
    input  rw_valid_o, rw_req_o, rw_addr_o, rw_size_o, data_write_o, w_mask_o, rw_id_o,
    output rw_ready_i, data_read_i, rw_resp_i
  );
endinterface

// File: rtl/rw_arbiter.sv
// rw_arbiter: three-port (icache, dcache, uncache) arbiter in front of a
// single AXI read/write master. One transaction in flight at a time:
// IDLE -> BUSY (request latched, shown to master) -> RESP (one-cycle ready).
//
// Build option ARB_ROUND_ROBIN_EN: when defined, the search starts at the
// port after the last grant (ic -> dc -> uc -> ic). When undefined, fixed
// priority dc > uc > ic and no pointer register exists.
//
// dbg_state exposes the FSM state (0 = IDLE, 1 = BUSY, 2 = RESP).
module rw_arbiter #(
  parameter int RW_ADDR_WIDTH = 64,
  parameter int RW_DATA_WIDTH = 64,
  parameter int ID_WIDTH      = 4
) (
  input  logic         clock,
  input  logic         reset,
  rw_arbiter_if.slave  bus,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;

  // Port index order in all 3-bit vectors: [0] = ic, [1] = dc, [2] = uc.
  logic [2:0] valid_vec;
  logic [2:0] pick;
  logic [2:0] grant;
  logic [2:0] ready_q;

  logic                     lat_req;
  logic [RW_ADDR_WIDTH-1:0] lat_addr;
  logic [1:0]               lat_size;
  logic [RW_DATA_WIDTH-1:0] lat_wdata;
  logic [7:0]               lat_wmask;

  logic                     sel_req;
  logic [RW_ADDR_WIDTH-1:0] sel_addr;
  logic [1:0]               sel_size;
  logic [RW_DATA_WIDTH-1:0] sel_wdata;
  logic [7:0]               sel_wmask;

  logic [RW_DATA_WIDTH-1:0] rdata_q [3];
  logic [1:0]               resp_q  [3];

  assign valid_vec = {bus.uc_valid_i, bus.dc_valid_i, bus.ic_valid_i};

`ifdef ARB_ROUND_ROBIN_EN
  // Index of the most recent grant; reset value 0 (ic) makes dc first.
  logic [1:0] rr_ptr;

  // Rotating search starting just after the last granted port
  always_comb begin
    pick = '0;
    case (rr_ptr)
      2'd0: begin
        if      (valid_vec[1]) pick = 3'b010;
        else if (valid_vec[2]) pick = 3'b100;
        else if (valid_vec[0]) pick = 3'b001;
      end
      2'd1: begin
        if      (valid_vec[2]) pick = 3'b100;
        else if (valid_vec[0]) pick = 3'b001;
        else if (valid_vec[1]) pick = 3'b010;
      end
      default: begin
        if      (valid_vec[0]) pick = 3'b001;
        else if (valid_vec[1]) pick = 3'b010;
        else if (valid_vec[2]) pick = 3'b100;
      end
    endcase
  end
`else
  // Fixed priority: dc first, then uc, then ic
  always_comb begin
    pick = '0;
    if      (valid_vec[1]) pick = 3'b010;
    else if (valid_vec[2]) pick = 3'b100;
    else if (valid_vec[0]) pick = 3'b001;
  end
`endif

  // Request fields of the port about to be granted
  always_comb begin
    sel_req   = bus.ic_req_i;
    sel_addr  = bus.ic_addr_i;
    sel_size  = bus.ic_size_i;
    sel_wdata = bus.ic_wdata_i;
    sel_wmask = bus.ic_wmask_i;
    if (pick[1]) begin
      sel_req   = bus.dc_req_i;
      sel_addr  = bus.dc_addr_i;
      sel_size  = bus.dc_size_i;
      sel_wdata = bus.dc_wdata_i;
      sel_wmask = bus.dc_wmask_i;
    end else if (pick[2]) begin
      sel_req   = bus.uc_req_i;
      sel_addr  = bus.uc_addr_i;
      sel_size  = bus.uc_size_i;
      sel_wdata = bus.uc_wdata_i;
      sel_wmask = bus.uc_wmask_i;
    end
  end

  // Transaction FSM: grant and latch, wait for master, pulse port ready
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= '0;
      ready_q   <= '0;
      lat_req   <= 1'b0;
      lat_addr  <= '0;
      lat_size  <= '0;
      lat_wdata <= '0;
      lat_wmask <= '0;
      for (int i = 0; i < 3; i++) begin
        rdata_q[i] <= '0;
        resp_q[i]  <= '0;
      end
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr    <= 2'd0;
`endif
    end else begin
      ready_q <= '0;
      case (state)
        IDLE: begin
          if (|valid_vec) begin
            grant     <= pick;
            lat_req   <= sel_req;
            lat_addr  <= sel_addr;
            lat_size  <= sel_size;
            lat_wdata <= sel_wdata;
            lat_wmask <= sel_wmask;
            state     <= BUSY;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr    <= pick[1] ? 2'd1 : (pick[2] ? 2'd2 : 2'd0);
`endif
          end
        end
        BUSY: begin
          if (bus.rw_ready_i) begin
            for (int i = 0; i < 3; i++) begin
              if (grant[i]) begin
                rdata_q[i] <= bus.data_read_i;
                resp_q[i]  <= bus.rw_resp_i;
              end
            end
            ready_q <= grant;
            state   <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Valid drops combinationally in the cycle the master's ready pulses
  assign bus.rw_valid_o   = (state == BUSY) & ~bus.rw_ready_i;
  assign bus.rw_req_o     = lat_req;
  assign bus.rw_addr_o    = lat_addr;
  assign bus.rw_size_o    = lat_size;
  assign bus.data_write_o = lat_wdata;
  assign bus.w_mask_o     = lat_wmask;
  assign bus.rw_id_o      = ID_WIDTH'(grant);

  assign bus.ic_ready_o = ready_q[0];
  assign bus.dc_ready_o = ready_q[1];
  assign bus.uc_ready_o = ready_q[2];
  assign bus.ic_rdata_o = rdata_q[0];
  assign bus.dc_rdata_o = rdata_q[1];
  assign bus.uc_rdata_o = rdata_q[2];
  assign bus.ic_resp_o  = resp_q[0];
  assign bus.dc_resp_o  = resp_q[1];
  assign bus.uc_resp_o  = resp_q[2];

  assign dbg_state = state;

endmodule

// File: tb/tb_rw_arbiter.sv
// Testbench for rw_arbiter: port drivers raise batches of requests, a
// behavioural model predicts the grant order and pushes expected master
// requests; an AXI responder pops and checks them and pushes expected
// completions; a completion monitor pops and checks port ready/rdata/resp.
module tb_rw_arbiter;

  localparam int AW    = 64;
  localparam int DW    = 64;
  localparam int IW    = 4;
  localparam int REQ_W = 141;  // {port[2], req, addr[64], size[2], wdata[64], wmask[8]}
  localparam int CMP_W = 68;   // {port[2], data[64], resp[2]}

  logic       clock;
  logic       reset;
  logic [1:0] dbg_state;

  rw_arbiter_if #(.RW_ADDR_WIDTH(AW), .RW_DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

  rw_arbiter #(.RW_ADDR_WIDTH(AW), .RW_DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- shared state ----------------
  int n_checks = 0;
  int n_pass   = 0;

  logic [REQ_W-1:0] exp_q[$];
  logic [CMP_W-1:0] cmp_q[$];

  // Per-port request fields chosen by the stimulus
  logic          p_req   [3];
  logic [AW-1:0] p_addr  [3];
  logic [1:0]    p_size  [3];
  logic [DW-1:0] p_wdata [3];
  logic [7:0]    p_wmask [3];

  // Responder controls
  bit            rsp_en;
  bit            rsp_fixed;
  logic [DW-1:0] rsp_data;
  logic [1:0]    rsp_resp;

  // Model: index of last granted port (round-robin build only)
  int rr_last;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- driver helpers ----------------
  task automatic drive_port(input int p, input logic v);
    case (p)
      0: begin
        bus.ic_valid_i = v; bus.ic_req_i = p_req[0]; bus.ic_addr_i = p_addr[0];
        bus.ic_size_i = p_size[0]; bus.ic_wdata_i = p_wdata[0]; bus.ic_wmask_i = p_wmask[0];
      end
      1: begin
        bus.dc_valid_i = v; bus.dc_req_i = p_req[1]; bus.dc_addr_i = p_addr[1];
        bus.dc_size_i = p_size[1]; bus.dc_wdata_i = p_wdata[1]; bus.dc_wmask_i = p_wmask[1];
      end
      default: begin
        bus.uc_valid_i = v; bus.uc_req_i = p_req[2]; bus.uc_addr_i = p_addr[2];
        bus.uc_size_i = p_size[2]; bus.uc_wdata_i = p_wdata[2]; bus.uc_wmask_i = p_wmask[2];
      end
    endcase
  endtask

  function automatic logic [2:0] ready_vec();
    return {bus.uc_ready_o, bus.dc_ready_o, bus.ic_ready_o};
  endfunction

  function automatic logic [DW-1:0] port_rdata(input int p);
    case (p)
      0:       return bus.ic_rdata_o;
      1:       return bus.dc_rdata_o;
      default: return bus.uc_rdata_o;
    endcase
  endfunction

  function automatic logic [1:0] port_resp(input int p);
    case (p)
      0:       return bus.ic_resp_o;
      1:       return bus.dc_resp_o;
      default: return bus.uc_resp_o;
    endcase
  endfunction

  task automatic randomize_port(input int p);
    p_req[p]   = 1'($urandom_range(0, 1));
    p_addr[p]  = {$urandom, $urandom};
    p_size[p]  = 2'($urandom_range(0, 3));
    p_wdata[p] = {$urandom, $urandom};
    p_wmask[p] = 8'($urandom_range(0, 255));
  endtask

  // ---------------- reference model ----------------
  // All ports in the mask present simultaneously and each drops out once
  // served, so the grant sequence is simply the priority order filtered
  // by the mask.
  task automatic model_batch(input logic [2:0] mask);
    int order[$];
`ifdef ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= 3; k++) begin
      int q;
      q = (rr_last + k) % 3;
      if (mask[q]) order.push_back(q);
    end
    if (order.size() != 0) rr_last = order[order.size()-1];
`else
    if (mask[1]) order.push_back(1);
    if (mask[2]) order.push_back(2);
    if (mask[0]) order.push_back(0);
`endif
    foreach (order[i]) begin
      int p;
      p = order[i];
      exp_q.push_back({2'(p), p_req[p], p_addr[p], p_size[p], p_wdata[p], p_wmask[p]});
    end
  endtask

  // Raise all ports in mask together, release each on its ready pulse
  task automatic run_batch(input logic [2:0] mask, input bit drop_ic);
    logic [2:0] done;
    int cyc;
    model_batch(mask);
    @(negedge clock);
    for (int p = 0; p < 3; p++) if (mask[p]) drive_port(p, 1'b1);
    done = '0;
    cyc  = 0;
    while (done != mask && cyc < 400) begin
      @(negedge clock);
      cyc++;
      if (drop_ic && bus.rw_valid_o && bus.rw_id_o == 4'b0001) bus.ic_valid_i = 1'b0;
      for (int p = 0; p < 3; p++) begin
        if (mask[p] && !done[p] && ready_vec()[p]) begin
          drive_port(p, 1'b0);
          done[p] = 1'b1;
        end
      end
    end
    check("batch_done", 64'(done), 64'(mask));
    repeat (2) @(negedge clock);
  endtask

  // ---------------- AXI responder (checks master requests) ----------------
  initial begin : responder
    logic [REQ_W-1:0] e;
    logic [REQ_W-3:0] snap;
    logic [DW-1:0]    d;
    logic [1:0]       r;
    int               lat;
    bus.rw_ready_i  = 1'b0;
    bus.data_read_i = '0;
    bus.rw_resp_i   = '0;
    forever begin
      @(negedge clock);
      if (!reset && rsp_en && bus.rw_valid_o) begin
        check("req_queue_empty", 64'(exp_q.size() == 0), 64'd0);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("rw_id",    64'(bus.rw_id_o),     64'd1 << e[140:139]);
          check("rw_req",   64'(bus.rw_req_o),    64'(e[138]));
          check("rw_addr",  bus.rw_addr_o,        e[137:74]);
          check("rw_size",  64'(bus.rw_size_o),   64'(e[73:72]));
          check("rw_wdata", bus.data_write_o,     e[71:8]);
          check("rw_wmask", 64'(bus.w_mask_o),    64'(e[7:0]));
          snap = {bus.rw_req_o, bus.rw_addr_o, bus.rw_size_o, bus.data_write_o, bus.w_mask_o};
          lat = $urandom_range(0, 3);
          repeat (lat) begin
            @(negedge clock);
            check("rw_valid_busy", 64'(bus.rw_valid_o), 64'd1);
            check("rw_stable", 64'(snap == {bus.rw_req_o, bus.rw_addr_o, bus.rw_size_o,
                                            bus.data_write_o, bus.w_mask_o}), 64'd1);
          end
          d = rsp_fixed ? rsp_data : {$urandom, $urandom};
          r = rsp_fixed ? rsp_resp : 2'($urandom_range(0, 3));
          bus.rw_ready_i  = 1'b1;
          bus.data_read_i = d;
          bus.rw_resp_i   = r;
          cmp_q.push_back({e[140:139], d, r});
          #1;
          check("rw_valid_on_ready", 64'(bus.rw_valid_o), 64'd0);
          @(negedge clock);
          bus.rw_ready_i = 1'b0;
          check("rw_valid_in_resp", 64'(bus.rw_valid_o), 64'd0);
        end
      end
    end
  end

  // ---------------- completion monitor ----------------
  initial begin : monitor
    logic [2:0]       rv;
    logic [2:0]       prev_rv;
    logic [CMP_W-1:0] c;
    logic [DW-1:0]    mem_d [3];
    logic [1:0]       mem_r [3];
    int               p;
    prev_rv = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        for (int i = 0; i < 3; i++) begin
          mem_d[i] = '0;
          mem_r[i] = '0;
        end
        prev_rv = '0;
      end else begin
        rv = ready_vec();
        if (rv != 3'b000) begin
          check("ready_onehot", 64'($countones(rv) == 1), 64'd1);
          check("ready_single_cycle", 64'(rv & prev_rv), 64'd0);
          check("cmp_queue_empty", 64'(cmp_q.size() == 0), 64'd0);
          if (cmp_q.size() != 0) begin
            c = cmp_q.pop_front();
            p = int'(c[67:66]);
            check("ready_port", 64'(rv), 64'd1 << p);
            mem_d[p] = c[65:2];
            mem_r[p] = c[1:0];
            for (int q = 0; q < 3; q++) begin
              check("port_rdata", port_rdata(q), mem_d[q]);
              check("port_resp",  64'(port_resp(q)), 64'(mem_r[q]));
            end
          end
        end
        prev_rv = rv;
      end
    end
  end

  // ---------------- main stimulus ----------------
  initial begin : stimulus
    int cyc;
    rsp_en    = 1'b1;
    rsp_fixed = 1'b0;
    rsp_data  = '0;
    rsp_resp  = '0;
    rr_last   = 0;
    for (int p = 0; p < 3; p++) begin
      p_req[p] = 1'b0; p_addr[p] = '0; p_size[p] = '0; p_wdata[p] = '0; p_wmask[p] = '0;
      drive_port(p, 1'b0);
    end
    reset = 1'b1;
    repeat (3) @(negedge clock);

    // Reset state
    check("rst_state",    64'(dbg_state),          64'd0);
    check("rst_rw_valid", 64'(bus.rw_valid_o),     64'd0);
    check("rst_ready",    64'(ready_vec()),        64'd0);
    check("rst_rw_addr",  bus.rw_addr_o,           64'd0);
    check("rst_rw_id",    64'(bus.rw_id_o),        64'd0);
    check("rst_rdata",    bus.ic_rdata_o | bus.dc_rdata_o | bus.uc_rdata_o, 64'd0);
    reset = 1'b0;
    @(negedge clock);

    // dcache read with known master data
    p_req[1] = 1'b0; p_addr[1] = 64'h80000008; p_size[1] = 2'd3;
    p_wdata[1] = '0; p_wmask[1] = '0;
    rsp_fixed = 1'b1; rsp_data = 64'h1122334455667788; rsp_resp = 2'd0;
    run_batch(3'b010, 1'b0);
    check("dc_rdata_known", bus.dc_rdata_o, 64'h1122334455667788);
    check("dc_resp_known",  64'(bus.dc_resp_o), 64'd0);
    rsp_fixed = 1'b0;

    // All three ports at once, twice
    for (int n = 0; n < 2; n++) begin
      for (int p = 0; p < 3; p++) randomize_port(p);
      run_batch(3'b111, 1'b0);
    end

    // Uncached write with partial mask
    p_req[2] = 1'b1; p_addr[2] = 64'ha00003f8; p_size[2] = 2'd2;
    p_wdata[2] = 64'hdeadbeef; p_wmask[2] = 8'h0f;
    run_batch(3'b100, 1'b0);

    // icache drops valid while its transaction is in BUSY
    randomize_port(0);
    run_batch(3'b001, 1'b1);

    // Reset while BUSY: grant dropped, no ready pulse
    rsp_en = 1'b0;
    randomize_port(0);
    @(negedge clock);
    drive_port(0, 1'b1);
    cyc = 0;
    while (!bus.rw_valid_o && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    check("busy_before_reset", 64'(bus.rw_valid_o), 64'd1);
    reset = 1'b1;
    bus.ic_valid_i = 1'b0;
    @(negedge clock);
    check("midrst_state",    64'(dbg_state),      64'd0);
    check("midrst_rw_valid", 64'(bus.rw_valid_o), 64'd0);
    check("midrst_ready",    64'(ready_vec()),    64'd0);
    reset   = 1'b0;
    rr_last = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clock);
      check("no_ready_after_reset", 64'(ready_vec()), 64'd0);
    end
    rsp_en = 1'b1;

    // Randomized batches
    for (int n = 0; n < 40; n++) begin
      logic [2:0] mask;
      mask = 3'($urandom_range(1, 7));
      for (int p = 0; p < 3; p++) randomize_port(p);
      run_batch(mask, 1'b0);
    end

    repeat (4) @(negedge clock);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("cmp_q_drained", 64'(cmp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
